seq_shift_add_mult: RTL and testbench



---
 rtl/seq_shift_add_mult_pkg.sv | 33 +++
 rtl/seq_shift_add_mult_if.sv | 36 +++
 rtl/seq_shift_add_mult.sv | 143 ++++++++++++++
 tb/tb_seq_shift_add_mult.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_shift_add_mult_pkg.sv
// ============================================================================
// Module   : mult_pkg
// Purpose  : Shared types and helpers for the sequential shift-add multiplier.
//            Holds the controller state encoding and the conditional
//            two's-complement magnitude helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_pkg;

   // Widest operand the helper below can handle.
   localparam int MAX_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Returns -val when negate is set, val otherwise. Callers zero-extend a
   // narrower operand and keep the low bits: the magnitude of the most
   // negative value still fits unsigned in the original width.
   function automatic logic [MAX_WIDTH-1:0] cond_mag(
      input logic [MAX_WIDTH-1:0] val,
      input logic                 negate
   );
      return negate ? (~val + 1'b1) : val;
   endfunction

endpackage

`default_nettype wire

// File: rtl/seq_shift_add_mult_if.sv
// ============================================================================
// Module   : seq_shift_add_mult_if
// Purpose  : Operand/result handshake bundle for seq_shift_add_mult.
//   in_valid/in_ready   : operand handshake (a, b, is_signed)
//   out_valid/out_ready : result handshake (result)
//   busy                : multiplier is in RUN or DONE
//   master modport = producer/consumer side, slave modport = multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_shift_add_mult_if #(
   parameter int WIDTH = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 is_signed;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   result;
   logic                 busy;

   modport master (
      output in_valid, a, b, is_signed, out_ready,
      input  in_ready, out_valid, result, busy
   );

   modport slave (
      input  in_valid, a, b, is_signed, out_ready,
      output in_ready, out_valid, result, busy
   );
endinterface

`default_nettype wire

// File: rtl/seq_shift_add_mult.sv
// ============================================================================
// Module   : seq_shift_add_mult
// Purpose  : Sequential shift-add multiplier, one multiplier bit per cycle.
//            Signed operation multiplies magnitudes and negates the product at
//            the end. With EARLY_TERM set the run stops once no multiplier
//            bits remain.
// Ports    : clk   - clock, rising edge
//            reset - synchronous, active-high
//            bus   - seq_shift_add_mult_if.slave (operand/result handshakes)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_shift_add_mult #(
   parameter int WIDTH      = 8,
   parameter bit EARLY_TERM = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   seq_shift_add_mult_if.slave  bus
);
   import mult_pkg::*;

   localparam int             CW   = $clog2(WIDTH + 1);
   localparam int             RW   = 2 * WIDTH;
   localparam logic [CW-1:0]  LAST = CW'(WIDTH);

   state_t           state_q,     state_d;
   logic [WIDTH-1:0] mplier_q,    mplier_d;
   logic [RW-1:0]    mcand_q,     mcand_d;
   logic [RW-1:0]    prod_q,      prod_d;
   logic [CW-1:0]    count_q,     count_d;
   logic             neg_q,       neg_d;
   logic [RW-1:0]    result_q,    result_d;
   logic             out_valid_q, out_valid_d;
   logic             in_ready_q,  in_ready_d;
   logic             busy_q,      busy_d;

   logic [MAX_WIDTH-1:0] a_ext;
   logic [MAX_WIDTH-1:0] b_ext;
   logic                 a_neg;
   logic                 b_neg;
   logic                 finish;

   always_comb begin
      a_ext              = '0;
      b_ext              = '0;
      a_ext[WIDTH-1:0]   = bus.a;
      b_ext[WIDTH-1:0]   = bus.b;
      a_neg              = bus.is_signed && bus.a[WIDTH-1];
      b_neg              = bus.is_signed && bus.b[WIDTH-1];
      // All multiplier bits consumed, or nothing left that could add in.
      finish             = (count_q == LAST) || (EARLY_TERM && (mplier_q == '0));

      state_d     = state_q;
      mplier_d    = mplier_q;
      mcand_d     = mcand_q;
      prod_d      = prod_q;
      count_d     = count_q;
      neg_d       = neg_q;
      result_d    = result_q;
      out_valid_d = out_valid_q;
      in_ready_d  = in_ready_q;
      busy_d      = busy_q;

      case (state_q)
         IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               mplier_d   = WIDTH'(cond_mag(a_ext, a_neg));
               mcand_d    = {{WIDTH{1'b0}}, WIDTH'(cond_mag(b_ext, b_neg))};
               neg_d      = a_neg ^ b_neg;
               prod_d     = '0;
               count_d    = '0;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
               state_d    = RUN;
            end
         end
         RUN: begin
            if (finish) begin
               result_d    = neg_q ? (~prod_q + 1'b1) : prod_q;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               if (mplier_q[0]) begin
                  prod_d = prod_q + mcand_q;
               end
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               count_d  = count_q + 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               busy_d      = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            busy_d      = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         mplier_q    <= '0;
         mcand_q     <= '0;
         prod_q      <= '0;
         count_q     <= '0;
         neg_q       <= 1'b0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mplier_q    <= mplier_d;
         mcand_q     <= mcand_d;
         prod_q      <= prod_d;
         count_q     <= count_d;
         neg_q       <= neg_d;
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.result    = result_q;
   assign bus.out_valid = out_valid_q;
   assign bus.in_ready  = in_ready_q;
   assign bus.busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_shift_add_mult.sv
// ============================================================================
// Module   : tb_seq_shift_add_mult
// Purpose  : Self-checking bench for seq_shift_add_mult. Three instances:
//            WIDTH=4 fixed latency, WIDTH=8 early termination, WIDTH=13
//            fixed latency. Products and latencies come from a plain
//            arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_shift_add_mult;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   seq_shift_add_mult_if #(.WIDTH(4))  bus4 ();
   seq_shift_add_mult_if #(.WIDTH(8))  bus8 ();
   seq_shift_add_mult_if #(.WIDTH(13)) bus13 ();

   seq_shift_add_mult #(.WIDTH(4),  .EARLY_TERM(1'b0)) dut4  (.clk(clk), .reset(reset), .bus(bus4.slave));
   seq_shift_add_mult #(.WIDTH(8),  .EARLY_TERM(1'b1)) dut8  (.clk(clk), .reset(reset), .bus(bus8.slave));
   seq_shift_add_mult #(.WIDTH(13), .EARLY_TERM(1'b0)) dut13 (.clk(clk), .reset(reset), .bus(bus13.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic longint ref_prod(input int w, input longint a, input longint b, input bit s);
      longint av, bv, mask;
      av = a;
      bv = b;
      if (s && av >= (longint'(1) << (w - 1))) av = av - (longint'(1) << w);
      if (s && bv >= (longint'(1) << (w - 1))) bv = bv - (longint'(1) << w);
      mask = (longint'(1) << (2 * w)) - 1;
      return (av * bv) & mask;
   endfunction

   function automatic int ref_lat(input int w, input bit et, input longint a, input bit s);
      longint mag;
      int     hb;
      if (!et) return w + 1;
      mag = a;
      if (s && a >= (longint'(1) << (w - 1))) mag = (longint'(1) << w) - a;
      if (mag == 0) return 1;
      hb = 0;
      for (int i = 0; i < w; i++) if (((mag >> i) & 1) == 1) hb = i;
      return hb + 2;
   endfunction

   // ---------------- per-instance transaction drivers ----------------
   // Each returns the captured result and the number of edges from the
   // accept edge until out_valid was seen (equal to the RUN cycle count).
   task automatic op4(input logic [3:0] a, input logic [3:0] b, input bit s, input int stall,
                      output longint res, output int runc);
      int guard;
      guard = 0;
      while (bus4.in_ready !== 1'b1 && guard < 50) begin @(posedge clk); #1; guard++; end
      bus4.a = a; bus4.b = b; bus4.is_signed = s; bus4.in_valid = 1'b1;
      bus4.out_ready = (stall == 0);
      @(posedge clk); #1;
      bus4.in_valid = 1'b0;
      runc = 0;
      do begin @(posedge clk); #1; runc++; end while (bus4.out_valid !== 1'b1 && runc < 100);
      res = longint'(bus4.result);
      repeat (stall) begin
         @(posedge clk); #1;
         checks++;
         if (bus4.out_valid !== 1'b1 || longint'(bus4.result) !== res || bus4.in_ready !== 1'b0) begin
            errors++; $display("FAIL w4_hold: valid=%b result=%h ready=%b want 1/%h/0", bus4.out_valid, bus4.result, bus4.in_ready, res);
         end
      end
      bus4.out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1 || bus4.busy !== 1'b0) begin
         errors++; $display("FAIL w4_handshake: valid=%b ready=%b busy=%b want 0/1/0", bus4.out_valid, bus4.in_ready, bus4.busy);
      end
      bus4.out_ready = 1'b0;
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit s, input int stall,
                      input bit poke, output longint res, output int runc);
      int guard;
      guard = 0;
      while (bus8.in_ready !== 1'b1 && guard < 50) begin @(posedge clk); #1; guard++; end
      bus8.a = a; bus8.b = b; bus8.is_signed = s; bus8.in_valid = 1'b1;
      bus8.out_ready = (stall == 0);
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      runc = 0;
      do begin @(posedge clk); #1; runc++; end while (bus8.out_valid !== 1'b1 && runc < 100);
      res = longint'(bus8.result);
      for (int k = 0; k < stall; k++) begin
         // A stray operand offer while the result drains must be ignored.
         if (poke && k == 1) begin bus8.a = ~a; bus8.b = ~b; bus8.in_valid = 1'b1; end
         if (poke && k == 3) bus8.in_valid = 1'b0;
         @(posedge clk); #1;
         checks++;
         if (bus8.out_valid !== 1'b1 || longint'(bus8.result) !== res || bus8.in_ready !== 1'b0 || bus8.busy !== 1'b1) begin
            errors++; $display("FAIL w8_hold: valid=%b result=%h ready=%b busy=%b want 1/%h/0/1", bus8.out_valid, bus8.result, bus8.in_ready, bus8.busy, res);
         end
      end
      bus8.in_valid  = 1'b0;
      bus8.out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1 || bus8.busy !== 1'b0) begin
         errors++; $display("FAIL w8_handshake: valid=%b ready=%b busy=%b want 0/1/0", bus8.out_valid, bus8.in_ready, bus8.busy);
      end
      bus8.out_ready = 1'b0;
   endtask

   task automatic op13(input logic [12:0] a, input logic [12:0] b, input bit s, input int stall,
                       output longint res, output int runc);
      int guard;
      guard = 0;
      while (bus13.in_ready !== 1'b1 && guard < 50) begin @(posedge clk); #1; guard++; end
      bus13.a = a; bus13.b = b; bus13.is_signed = s; bus13.in_valid = 1'b1;
      bus13.out_ready = (stall == 0);
      @(posedge clk); #1;
      bus13.in_valid = 1'b0;
      runc = 0;
      do begin @(posedge clk); #1; runc++; end while (bus13.out_valid !== 1'b1 && runc < 100);
      res = longint'(bus13.result);
      repeat (stall) begin
         @(posedge clk); #1;
         checks++;
         if (bus13.out_valid !== 1'b1 || longint'(bus13.result) !== res || bus13.in_ready !== 1'b0) begin
            errors++; $display("FAIL w13_hold: valid=%b result=%h ready=%b want 1/%h/0", bus13.out_valid, bus13.result, bus13.in_ready, res);
         end
      end
      bus13.out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus13.out_valid !== 1'b0 || bus13.in_ready !== 1'b1 || bus13.busy !== 1'b0) begin
         errors++; $display("FAIL w13_handshake: valid=%b ready=%b busy=%b want 0/1/0", bus13.out_valid, bus13.in_ready, bus13.busy);
      end
      bus13.out_ready = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      checks++;
      if (bus4.out_valid !== 1'b0 || bus4.result !== 8'h00 || bus4.busy !== 1'b0 || bus4.in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_w4: valid=%b result=%h busy=%b ready=%b want 0/0/0/1", bus4.out_valid, bus4.result, bus4.busy, bus4.in_ready);
      end
      checks++;
      if (bus8.out_valid !== 1'b0 || bus8.result !== 16'h0000 || bus8.busy !== 1'b0 || bus8.in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_w8: valid=%b result=%h busy=%b ready=%b want 0/0/0/1", bus8.out_valid, bus8.result, bus8.busy, bus8.in_ready);
      end
      checks++;
      if (bus13.out_valid !== 1'b0 || bus13.result !== 26'h0 || bus13.busy !== 1'b0 || bus13.in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_w13: valid=%b result=%h busy=%b ready=%b want 0/0/0/1", bus13.out_valid, bus13.result, bus13.busy, bus13.in_ready);
      end
   endtask

   task automatic test_fixed_latency();
      longint res;
      int     runc;
      op4(4'hF, 4'hF, 1'b0, 0, res, runc);
      checks++;
      if (res !== 64'd225) begin errors++; $display("FAIL fixed_w4_result: got %0d want 225", res); end
      checks++;
      if (runc !== 5) begin errors++; $display("FAIL fixed_w4_latency: got %0d want 5", runc); end
      op4(4'h8, 4'h7, 1'b1, 2, res, runc);
      checks++;
      if (res !== ref_prod(4, 8, 7, 1'b1)) begin errors++; $display("FAIL fixed_w4_signed: got %h want %h", res, ref_prod(4, 8, 7, 1'b1)); end
   endtask

   task automatic test_signed();
      longint res;
      int     runc;
      op8(8'h80, 8'hFF, 1'b1, 0, 1'b0, res, runc);
      checks++;
      if (res !== ref_prod(8, 'h80, 'hFF, 1'b1)) begin errors++; $display("FAIL signed_min_result: got %h want %h", res, ref_prod(8, 'h80, 'hFF, 1'b1)); end
      checks++;
      if (runc !== ref_lat(8, 1'b1, 'h80, 1'b1)) begin errors++; $display("FAIL signed_min_latency: got %0d want %0d", runc, ref_lat(8, 1'b1, 'h80, 1'b1)); end
      op8(8'h03, 8'hFB, 1'b1, 1, 1'b0, res, runc);
      checks++;
      if (res !== ref_prod(8, 3, 'hFB, 1'b1)) begin errors++; $display("FAIL signed_3x-5_result: got %h want %h", res, ref_prod(8, 3, 'hFB, 1'b1)); end
      checks++;
      if (runc !== 3) begin errors++; $display("FAIL signed_3x-5_latency: got %0d want 3", runc); end
   endtask

   task automatic test_early_term();
      longint res;
      int     runc;
      op8(8'h00, 8'hAB, 1'b0, 0, 1'b0, res, runc);
      checks++;
      if (res !== 64'd0) begin errors++; $display("FAIL early_zero_result: got %h want 0", res); end
      checks++;
      if (runc !== 1) begin errors++; $display("FAIL early_zero_latency: got %0d want 1", runc); end
      op8(8'hFF, 8'hFF, 1'b0, 0, 1'b0, res, runc);
      checks++;
      if (res !== ref_prod(8, 'hFF, 'hFF, 1'b0)) begin errors++; $display("FAIL early_full_result: got %h want %h", res, ref_prod(8, 'hFF, 'hFF, 1'b0)); end
      checks++;
      if (runc !== 9) begin errors++; $display("FAIL early_full_latency: got %0d want 9", runc); end
   endtask

   task automatic test_backpressure();
      longint res;
      int     runc;
      op8(8'h5A, 8'h3C, 1'b0, 5, 1'b1, res, runc);
      checks++;
      if (res !== ref_prod(8, 'h5A, 'h3C, 1'b0)) begin errors++; $display("FAIL bp_result: got %h want %h", res, ref_prod(8, 'h5A, 'h3C, 1'b0)); end
      // The ignored offer must not have started a second transaction.
      repeat (3) begin
         @(posedge clk); #1;
         checks++;
         if (bus8.busy !== 1'b0 || bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_no_dup: busy=%b valid=%b ready=%b want 0/0/1", bus8.busy, bus8.out_valid, bus8.in_ready);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      longint res;
      int     runc;
      bus8.a = 8'hFF; bus8.b = 8'h11; bus8.is_signed = 1'b0; bus8.in_valid = 1'b1;
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if (bus8.out_valid !== 1'b0 || bus8.result !== 16'h0000 || bus8.busy !== 1'b0 || bus8.in_ready !== 1'b1) begin
         errors++; $display("FAIL mid_reset: valid=%b result=%h busy=%b ready=%b want 0/0/0/1", bus8.out_valid, bus8.result, bus8.busy, bus8.in_ready);
      end
      op8(8'd7, 8'd9, 1'b0, 0, 1'b0, res, runc);
      checks++;
      if (res !== 64'd63) begin errors++; $display("FAIL mid_reset_after: got %0d want 63", res); end
   endtask

   task automatic test_random();
      longint      res;
      longint      expv;
      int          runc;
      int          expl;
      logic [31:0] ra, rb;
      bit          rs;
      int          st;
      for (int i = 0; i < 1000; i++) begin
         ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1)); st = $urandom_range(0, 3);
         op8(ra[7:0], rb[7:0], rs, st, 1'b0, res, runc);
         expv = ref_prod(8, longint'(ra[7:0]), longint'(rb[7:0]), rs);
         expl = ref_lat(8, 1'b1, longint'(ra[7:0]), rs);
         checks++;
         if (res !== expv) begin errors++; $display("FAIL rand_w8_result: a=%h b=%h s=%b got %h want %h", ra[7:0], rb[7:0], rs, res, expv); end
         checks++;
         if (runc !== expl) begin errors++; $display("FAIL rand_w8_latency: a=%h s=%b got %0d want %0d", ra[7:0], rs, runc, expl); end
      end
      for (int i = 0; i < 1000; i++) begin
         ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1)); st = $urandom_range(0, 3);
         op13(ra[12:0], rb[12:0], rs, st, res, runc);
         expv = ref_prod(13, longint'(ra[12:0]), longint'(rb[12:0]), rs);
         expl = ref_lat(13, 1'b0, longint'(ra[12:0]), rs);
         checks++;
         if (res !== expv) begin errors++; $display("FAIL rand_w13_result: a=%h b=%h s=%b got %h want %h", ra[12:0], rb[12:0], rs, res, expv); end
         checks++;
         if (runc !== expl) begin errors++; $display("FAIL rand_w13_latency: got %0d want %0d", runc, expl); end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      bus4.in_valid = 1'b0;  bus4.a = '0;  bus4.b = '0;  bus4.is_signed = 1'b0;  bus4.out_ready = 1'b0;
      bus8.in_valid = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.is_signed = 1'b0;  bus8.out_ready = 1'b0;
      bus13.in_valid = 1'b0; bus13.a = '0; bus13.b = '0; bus13.is_signed = 1'b0; bus13.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      test_reset();
      test_fixed_latency();
      test_signed();
      test_early_term();
      test_backpressure();
      test_reset_mid_run();
      test_random();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
